conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Parametrised K×K sliding-window generator for multi-channel feature-map lines. It receives K vertically aligned padded lines per beat, one pixel column per channel, from the line buffers. It emits one K×K window per channel, with runtime stride 1 or 2, an internal column count, and end-of-line signalling. It sits between the line-buffer block and the convolution MAC array, and succeeds the fixed 3×3 / 8-channel window generator.

## Interface
- `CH`, 8, channel count
- `DW`, 8, bits per pixel
- `K`, 3, window size; legal 3 or 5
- `IMG_W`, 418, padded line width in columns
- `CW`, `$clog2(IMG_W)`, column-counter width (derived)
- `sclk` in 1: clock
- `s_rst_n` in 1: reset; asynchronous, active-low
- `line_data` in K·CH·DW: row r at `[r*CH*DW +: CH*DW]`, where r=0 is the oldest/top line; channel c at `[c*DW +: DW]` within the row
- `line_data_vld` in 1: one column beat
- `line_clr` in 1: synchronous line restart
- `stride_sel` in 1: 0 → stride 1, 1 → stride 2
- `win_data` out CH·K·K·DW: channel c at `[c*K*K*DW +: K*K*DW]`; element (r,col) at `[(r*K+col)*DW +: DW]` within the channel, where col=0 is the oldest column
- `win_vld` out 1: `win_data` holds a valid window
- `win_col` out CW: left-edge column index of the window
- `line_end` out 1: one-cycle pulse after the last beat of a line

## Operation
- Per channel, a K×K register array. On each `line_data_vld`, columns shift left (col 0 dropped) and the new K-row column enters at col K−1.
- `col_cnt` (CW bits) is the index of the current beat. It increments per beat and wraps to 0 after `IMG_W−1`.
- `stride_q` loads from `stride_sel` only on a beat with `col_cnt==0`. Mid-line changes are ignored.
- State FILL while `col_cnt < K−1`: no window is emitted.
- FILL → RUN on the beat with `col_cnt==K−1`.
- RUN → FILL on the beat with `col_cnt==IMG_W−1`, or on `line_clr`.
- Emit a window on a RUN beat when `(col_cnt−(K−1))` is a multiple of `stride_q`. The stride-2 phase uses a toggle reset at `col_cnt==K−1`, not a divider.
- `win_col` = `col_cnt−(K−1)` of the emitting beat.
- `line_end` is asserted for the beat with `col_cnt==IMG_W−1`, whether or not that beat emits a window.
- `line_clr` has priority. It sets `col_cnt` and the stride toggle to 0 and enters FILL; shift arrays are not cleared. A coincident `line_data_vld` beat is accepted as column 0 of the new line, with `stride_q` loaded.
- Gaps in `line_data_vld` (idle cycles) hold all state, and `win_vld` is 0 during them.

## Timing
- Latency: 1 cycle. `win_data`, `win_vld`, `win_col` and `line_end` are registered and reflect the window completed by the beat of the previous cycle.
- `win_data` holds its value when `win_vld` is 0. Consumers sample only when `win_vld` is 1.
- Reset values:
  - all shift registers 0
  - `col_cnt` 0, state FILL, `stride_q` stride 1
  - `win_data` 0, `win_vld` 0, `win_col` 0, `line_end` 0
- Reset asserted mid-line drops the line. After release the next beat is column 0.
- Windows per line:
  - stride 1: IMG_W−K+1
  - stride 2: ⌈(IMG_W−K+1)/2⌉
- Throughput: one window per cycle at full input rate. There is no backpressure; the downstream side must accept every `win_vld`.

## Structure
- Package `conv_pkg`:
  - `K_MAX=5`
  - function `win_idx(r,col,K)` returning the element bit offset
  - stride enum `STRIDE_1`/`STRIDE_2`
- Sub-module `conv_window_ch` (params `DW`, `K`): one channel's K×K shift array. Inputs: shift enable and the K-pixel column. Output: packed K·K·DW window.
- Top generates `CH` instances and holds the shared `col_cnt`, state, stride logic and output registers.

## Test plan
Beds use CH=2, DW=8, IMG_W=6; pixel value = 16·row + column.
- Reset/idle (K=3): after reset with no beats → all outputs 0; `win_vld` never rises.
- Stride 1 (K=3): 6 contiguous beats → 4 windows with `win_col` 0,1,2,3; first window row0 = 0x00,0x01,0x02; `line_end` 1 cycle after beat 5.
- Stride 2 (K=3): `stride_sel=1` at column 0 → 2 windows, `win_col` 0 and 2. Toggling `stride_sel` mid-line → no change in output.
- Gapped input (K=5): beats with idle cycles between → 2 windows, `win_col` 0,1, with contents identical to the contiguous case.
- `line_clr` at column 3 coincident with a beat → that beat becomes column 0 and no window appears until 2 further beats. Async reset mid-line → outputs 0 immediately, and the next line starts at column 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the sliding-window generator.
package conv_pkg;

  localparam int K_MAX = 5;

  typedef enum logic {
    STRIDE_1 = 1'b0,
    STRIDE_2 = 1'b1
  } stride_e;

  // Bit offset of window element (r, col) inside one channel's packed window.
  function automatic int win_idx(input int r, input int col, input int k, input int dw);
    return (r * k + col) * dw;
  endfunction

endpackage

// File: rtl/conv_window_ch.sv
// One channel's K x K column-shift array; presents the window as it stands
// after the current column is shifted in.
module conv_window_ch
  import conv_pkg::*;
#(
  parameter int DW = 8,
  parameter int K  = 3
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              shift_en,
  input  logic [K*DW-1:0]   col_in,
  output logic [K*K*DW-1:0] win
);

  // Only the K-1 newest columns need storage: the oldest column of the
  // window is dropped on the very shift that exposes the new one.
  logic [K*(K-1)*DW-1:0] hist_q;
  logic [K*(K-1)*DW-1:0] hist_d;
  logic [K*K*DW-1:0]     win_d;

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      if (c < K-1) begin : g_old
        assign win_d[win_idx(r, c, K, DW) +: DW] = hist_q[win_idx(r, c, K-1, DW) +: DW];
        assign hist_d[win_idx(r, c, K-1, DW) +: DW] = win_d[win_idx(r, c+1, K, DW) +: DW];
      end else begin : g_new
        assign win_d[win_idx(r, c, K, DW) +: DW] = col_in[r*DW +: DW];
      end
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      hist_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_d;
    end
  end

  assign win = win_d;

endmodule

// File: rtl/conv_window_gen.sv
// K x K multi-channel sliding-window generator with runtime stride 1/2,
// internal column count and end-of-line pulse; one-cycle output latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_FILL | first K-1 columns of a line; array not yet full, no output
// ST_RUN  | array full; windows emitted at the selected stride
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int CH    = 8,
  parameter int DW    = 8,
  parameter int K     = 3,
  parameter int IMG_W = 418,
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic                 sclk,
  input  logic                 s_rst_n,
  input  logic [K*CH*DW-1:0]   line_data,
  input  logic                 line_data_vld,
  input  logic                 line_clr,
  input  logic                 stride_sel,
  output logic [CH*K*K*DW-1:0] win_data,
  output logic                 win_vld,
  output logic [CW-1:0]        win_col,
  output logic                 line_end
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]           state;
  logic [CW-1:0]        col_cnt;
  logic                 tog;
  stride_e              stride_q;
  logic [CH*K*K*DW-1:0] win_next;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [K*DW-1:0] col_in;
    for (genvar r = 0; r < K; r++) begin : g_row
      assign col_in[r*DW +: DW] = line_data[(r*CH + c)*DW +: DW];
    end
    conv_window_ch #(.DW(DW), .K(K)) u_ch (
      .sclk     (sclk),
      .s_rst_n  (s_rst_n),
      .shift_en (line_data_vld),
      .col_in   (col_in),
      .win      (win_next[c*K*K*DW +: K*K*DW])
    );
  end

  // A line_clr beat is column 0 of the new line.
  logic [CW-1:0] col_cur;
  logic          first_run;
  logic          last_col;
  logic          run_beat;
  logic          tog_cur;
  logic          emit;

  assign col_cur   = line_clr ? '0 : col_cnt;
  assign first_run = (col_cur == CW'(K-1));
  assign last_col  = (col_cur == CW'(IMG_W-1));
  assign run_beat  = ((state == ST_RUN) && !line_clr) || first_run;
  assign tog_cur   = first_run ? 1'b0 : tog;
  assign emit      = line_data_vld && run_beat && ((stride_q == STRIDE_1) || !tog_cur);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= ST_FILL;
      col_cnt  <= '0;
      tog      <= 1'b0;
      stride_q <= STRIDE_1;
      win_data <= '0;
      win_vld  <= 1'b0;
      win_col  <= '0;
      line_end <= 1'b0;
    end else begin
      if (line_clr) begin
        state   <= ST_FILL;
        col_cnt <= '0;
        tog     <= 1'b0;
      end
      if (line_data_vld) begin
        col_cnt <= last_col ? '0 : col_cur + CW'(1);
        if (col_cur == '0) stride_q <= stride_e'(stride_sel);
        if (first_run) state <= ST_RUN;
        else if (last_col) state <= ST_FILL;
        if (run_beat) tog <= ~tog_cur;
      end
      win_vld  <= emit;
      line_end <= line_data_vld && last_col;
      if (emit) begin
        win_data <= win_next;
        win_col  <= col_cur - CW'(K-1);
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: K=3 and K=5 instances, CH=2, IMG_W=6.
module tb_conv_window_gen;

  localparam int CH    = 2;
  localparam int DW    = 8;
  localparam int IMG_W = 6;
  localparam int CW    = $clog2(IMG_W);
  localparam int WB    = 400;

  logic sclk = 1'b0;
  logic s_rst_n = 1'b0;

  logic [3*CH*DW-1:0]   ld3;
  logic                 vld3, clr3, ss3;
  logic [CH*9*DW-1:0]   wd3;
  logic                 wv3, le3;
  logic [CW-1:0]        wc3;

  logic [5*CH*DW-1:0]   ld5;
  logic                 vld5, clr5, ss5;
  logic [CH*25*DW-1:0]  wd5;
  logic                 wv5, le5;
  logic [CW-1:0]        wc5;

  conv_window_gen #(.CH(CH), .DW(DW), .K(3), .IMG_W(IMG_W)) dut3 (
    .sclk(sclk), .s_rst_n(s_rst_n), .line_data(ld3), .line_data_vld(vld3),
    .line_clr(clr3), .stride_sel(ss3), .win_data(wd3), .win_vld(wv3),
    .win_col(wc3), .line_end(le3)
  );

  conv_window_gen #(.CH(CH), .DW(DW), .K(5), .IMG_W(IMG_W)) dut5 (
    .sclk(sclk), .s_rst_n(s_rst_n), .line_data(ld5), .line_data_vld(vld5),
    .line_clr(clr5), .stride_sel(ss5), .win_data(wd5), .win_vld(wv5),
    .win_col(wc5), .line_end(le5)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    bit            k5;
    bit            emit;
    logic [WB-1:0] data;
    int            col;
    bit            lend;
  } exp_t;

  exp_t          exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            m_col[2];
  int            m_str[2];
  int            hist3[$];
  int            hist5[$];
  logic [WB-1:0] last_win[2];
  int            nwin[2];

  task automatic check_val(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c, input int x);
    return 8'(16*r + x + 128*c);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_col[i] = 0;
      m_str[i] = 1;
      last_win[i] = '0;
      nwin[i] = 0;
    end
    hist3.delete();
    hist5.delete();
  endtask

  task automatic beat(input bit k5, input int x, input bit clr, input bit ssel);
    int   k;
    int   i;
    int   h[5];
    exp_t e;
    exp_t g;
    logic [WB-1:0] gd;
    logic gv, gl, ov;
    logic [CW-1:0] gc;
    k = k5 ? 5 : 3;
    i = k5 ? 1 : 0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < CH; c++)
        if (k5) ld5[(r*CH + c)*DW +: DW] = pix(r, c, x);
        else    ld3[(r*CH + c)*DW +: DW] = pix(r, c, x);
    if (k5) begin vld5 = 1'b1; clr5 = clr; ss5 = ssel; end
    else    begin vld3 = 1'b1; clr3 = clr; ss3 = ssel; end

    if (clr) m_col[i] = 0;
    if (m_col[i] == 0) m_str[i] = ssel ? 2 : 1;
    for (int j = 0; j < 5; j++) h[j] = 0;
    if (k5) begin
      hist5.push_back(x);
      if (hist5.size() > k) void'(hist5.pop_front());
      for (int j = 0; j < hist5.size(); j++) h[j] = hist5[j];
    end else begin
      hist3.push_back(x);
      if (hist3.size() > k) void'(hist3.pop_front());
      for (int j = 0; j < hist3.size(); j++) h[j] = hist3[j];
    end
    e.k5   = k5;
    e.emit = (m_col[i] >= k-1) && (((m_col[i] - (k-1)) % m_str[i]) == 0);
    e.col  = m_col[i] - (k-1);
    e.lend = (m_col[i] == IMG_W-1);
    e.data = '0;
    if (e.emit)
      for (int c = 0; c < CH; c++)
        for (int r = 0; r < k; r++)
          for (int j = 0; j < k; j++)
            e.data[((c*k + r)*k + j)*DW +: DW] = pix(r, c, h[j]);
    exp_q.push_back(e);
    m_col[i] = (m_col[i] == IMG_W-1) ? 0 : m_col[i] + 1;

    @(posedge sclk);
    #1;
    vld3 = 1'b0; clr3 = 1'b0; vld5 = 1'b0; clr5 = 1'b0;

    g  = exp_q.pop_front();
    gd = g.k5 ? WB'(wd5) : WB'(wd3);
    gv = g.k5 ? wv5 : wv3;
    gc = g.k5 ? wc5 : wc3;
    gl = g.k5 ? le5 : le3;
    ov = g.k5 ? wv3 : wv5;
    check_val("win_vld", WB'(gv), WB'(g.emit));
    if (g.emit) begin
      check_val("win_data", gd, g.data);
      check_val("win_col", WB'(gc), WB'(g.col));
      last_win[i] = g.data;
    end
    check_val("line_end", WB'(gl), WB'(g.lend));
    check_val("other_vld", WB'(ov), '0);
    if (gv) nwin[i]++;
  endtask

  task automatic idle();
    @(posedge sclk);
    #1;
    check_val("idle_vld3", WB'(wv3), '0);
    check_val("idle_vld5", WB'(wv5), '0);
    check_val("idle_lend3", WB'(le3), '0);
    check_val("idle_lend5", WB'(le5), '0);
    check_val("hold3", WB'(wd3), last_win[0]);
    check_val("hold5", WB'(wd5), last_win[1]);
  endtask

  initial begin
    ld3 = '0; vld3 = 1'b0; clr3 = 1'b0; ss3 = 1'b0;
    ld5 = '0; vld5 = 1'b0; clr5 = 1'b0; ss5 = 1'b0;
    model_reset();
    repeat (2) @(posedge sclk);
    #1;
    check_val("rst_vld3", WB'(wv3), '0);
    check_val("rst_data3", WB'(wd3), '0);
    check_val("rst_col3", WB'(wc3), '0);
    check_val("rst_lend3", WB'(le3), '0);
    check_val("rst_vld5", WB'(wv5), '0);
    check_val("rst_data5", WB'(wd5), '0);
    check_val("rst_col5", WB'(wc5), '0);
    check_val("rst_lend5", WB'(le5), '0);
    s_rst_n = 1'b1;
    repeat (3) idle();

    // stride 1, K=3
    nwin[0] = 0;
    for (int x = 0; x < 6; x++) beat(1'b0, x, 1'b0, 1'b0);
    check_val("count_s1", WB'(nwin[0]), WB'(4));
    idle();

    // stride 2, K=3, stride_sel toggled mid-line
    nwin[0] = 0;
    for (int x = 0; x < 6; x++) beat(1'b0, x, 1'b0, (x == 0) ? 1'b1 : 1'(x % 2));
    check_val("count_s2", WB'(nwin[0]), WB'(2));
    idle();

    // gapped input, K=5
    nwin[1] = 0;
    for (int x = 0; x < 6; x++) begin
      beat(1'b1, x, 1'b0, 1'b0);
      repeat (1 + x % 2) idle();
    end
    check_val("count_k5", WB'(nwin[1]), WB'(2));

    // line_clr coincident with the column-3 beat
    for (int x = 0; x < 3; x++) beat(1'b0, x, 1'b0, 1'b0);
    nwin[0] = 0;
    beat(1'b0, 3, 1'b1, 1'b0);
    beat(1'b0, 4, 1'b0, 1'b0);
    check_val("clr_no_win", WB'(nwin[0]), '0);
    for (int x = 5; x < 9; x++) beat(1'b0, x, 1'b0, 1'b0);
    check_val("count_clr", WB'(nwin[0]), WB'(4));
    idle();

    // asynchronous reset mid-line
    for (int x = 0; x < 4; x++) beat(1'b0, x, 1'b0, 1'b0);
    #2;
    s_rst_n = 1'b0;
    #1;
    check_val("arst_vld3", WB'(wv3), '0);
    check_val("arst_data3", WB'(wd3), '0);
    check_val("arst_col3", WB'(wc3), '0);
    check_val("arst_lend3", WB'(le3), '0);
    model_reset();
    @(posedge sclk);
    #1;
    s_rst_n = 1'b1;
    idle();
    for (int x = 0; x < 6; x++) beat(1'b0, x, 1'b0, 1'b0);
    check_val("count_after_rst", WB'(nwin[0]), WB'(4));
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
